dr_reorder_25: RTL and testbench

Radix-5 output reorder buffer for the 25-point FFT pipeline. It sits after the last butterfly/delay stage and is the reading counterpart to the pipeline's delay-line buffers. It captures a frame of 25 complex samples arriving in digit-reversed (base-5) order and replays them in natural order. Two ping-pong banks let one frame be written while the previous one is read, so continuous streaming needs no backpressure.

---
 rtl/fft_r5_pkg.sv | 22 ++
 rtl/dr_bank_25.sv | 22 ++
 rtl/dr_reorder_25.sv | 128 ++++++++++++
 tb/tb_dr_reorder_25.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_r5_pkg.sv
// Shared radix-5 FFT definitions.
// Used by the 25-point and 125-point pipelines.
package fft_r5_pkg;

  localparam int RADIX = 5;
  localparam int N25   = 25;
  localparam int DW    = 32;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] img;
  } cplx_t;

  function automatic logic [4:0] digit_rev5_2(input logic [4:0] k);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = k % 5'd5;
    hi = k / 5'd5;
    return 5'(lo * 5'd5 + hi);
  endfunction

endpackage

// File: rtl/dr_bank_25.sv
// One ping-pong bank of the 25-point reorder buffer:
// synchronous write, combinational read.
module dr_bank_25 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         we,
  input  logic [4:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [4:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [25];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dr_reorder_25.sv
// Radix-5 digit-reversed to natural order reorder buffer,
// 25-point frames, ping-pong banks, no backpressure.
module dr_reorder_25
  import fft_r5_pkg::digit_rev5_2;
#(
  parameter int DW = 32,
  parameter int N  = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_img,
  output logic          out_valid,
  output logic [DW-1:0] a1_re,
  output logic [DW-1:0] a1_img,
  output logic [4:0]    out_index,
  output logic          out_last
);

  localparam logic [4:0] LAST = 5'(N - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t state, state_nxt;

  logic [4:0]      wcnt, rcnt;
  logic            wsel, rsel;
  logic [1:0]      full, set_full, clr_full;
  logic            wr_wrap, rd_fire, rd_wrap;
  logic [4:0]      raddr;
  logic [2*DW-1:0] wdata, rd0, rd1, rdata;

  assign wr_wrap = in_valid && (wcnt == LAST);
  // A full bank at the read pointer is always being drained.
  assign rd_fire = full[rsel];
  assign rd_wrap = rd_fire && (rcnt == LAST);
  assign raddr   = digit_rev5_2(rcnt);
  assign wdata   = {a_re, a_img};
  assign rdata   = rsel ? rd1 : rd0;

  always_comb begin
    set_full = 2'b00;
    clr_full = 2'b00;
    if (wr_wrap) set_full[wsel] = 1'b1;
    if (rd_wrap) clr_full[rsel] = 1'b1;
  end

  dr_bank_25 #(.W(2*DW)) u_bank0 (
    .clk   (clk),
    .we    (in_valid && !wsel),
    .waddr (wcnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd0)
  );

  dr_bank_25 #(.W(2*DW)) u_bank1 (
    .clk   (clk),
    .we    (in_valid && wsel),
    .waddr (wcnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      wsel <= 1'b0;
    end else if (in_valid) begin
      wcnt <= wr_wrap ? 5'd0 : wcnt + 5'd1;
      if (wr_wrap) wsel <= ~wsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= (full | set_full) & ~clr_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (full[rsel]) state_nxt = READ;
      READ: if (rd_wrap)
              state_nxt = full[~rsel] ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      rsel <= 1'b0;
    end else if (rd_fire) begin
      rcnt <= rd_wrap ? 5'd0 : rcnt + 5'd1;
      if (rd_wrap) rsel <= ~rsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      a1_re     <= '0;
      a1_img    <= '0;
    end else begin
      out_valid <= rd_fire;
      out_last  <= rd_wrap;
      if (rd_fire) begin
        out_index <= rcnt;
        a1_re     <= rdata[2*DW-1:DW];
        a1_img    <= rdata[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dr_reorder_25.sv
// Scoreboard bench for dr_reorder_25: driver pushes
// expected natural-order samples, monitor pops and compares.
module tb_dr_reorder_25;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a_re = '0;
  logic [DW-1:0] a_img = '0;
  logic          out_valid;
  logic [DW-1:0] a1_re;
  logic [DW-1:0] a1_img;
  logic [4:0]    out_index;
  logic          out_last;

  dr_reorder_25 #(.DW(DW), .N(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_re      (a_re),
    .a_img     (a_img),
    .out_valid (out_valid),
    .a1_re     (a1_re),
    .a1_img    (a1_img),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] img;
    logic [4:0]  idx;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // natural index k -> arrival slot, computed by hand
  int dr_tab [25] = '{0, 5, 10, 15, 20,
                      1, 6, 11, 16, 21,
                      2, 7, 12, 17, 22,
                      3, 8, 13, 18, 23,
                      4, 9, 14, 19, 24};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int run = 0;
  int max_run = 0;
  int seen = 0;
  int first_cyc = -1;
  int last_edge = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // output monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        seen++;
        if (out_index == 5'd0 && first_cyc < 0) first_cyc = cyc;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out idx=%0d re=%0d required=none",
                   out_index, a1_re);
        end else begin
          e = q.pop_front();
          check("out_re", 64'(a1_re), 64'(e.re));
          check("out_img", 64'(a1_img), 64'(e.img));
          check("out_index", 64'(out_index), 64'(e.idx));
          check("out_last", 64'(out_last), 64'(e.idx == 5'd24));
        end
      end else begin
        run = 0;
        if (out_last) begin
          total++;
          bad++;
          $display("FAIL last_without_valid actual=1 required=0");
        end
      end
    end
  end

  // protocol properties of the full flags
  always @(posedge clk) begin
    if (rst_n) begin
      if ((dut.set_full & dut.clr_full) != 2'b00) begin
        bad++;
        $display("FAIL set_clr_same_bank actual=%b required=00",
                 dut.set_full & dut.clr_full);
      end
      if (in_valid && dut.full[dut.wsel]) begin
        bad++;
        $display("FAIL overflow actual=1 required=0 bank=%0d",
                 dut.wsel);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input int re, input int img);
    @(negedge clk);
    in_valid = 1'b1;
    a_re = DW'(re);
    a_img = DW'(img);
  endtask

  task automatic push_frame(input int bre, input int bimg);
    exp_t x;
    for (int k = 0; k < 25; k++) begin
      x.re = 32'(bre + dr_tab[k]);
      x.img = 32'(bimg + dr_tab[k]);
      x.idx = 5'(k);
      q.push_back(x);
    end
  endtask

  task automatic send_frame(input int bre, input int bimg,
                            input bit gap);
    push_frame(bre, bimg);
    for (int n = 0; n < 25; n++) begin
      send(bre + n, bimg + n);
      if (n == 24) last_edge = cyc + 1;
      else if (gap) idle(1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_data", {a1_re, a1_img}, 64'd0);
    q.delete();
    run = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_stats();
    max_run = 0;
    seen = 0;
    first_cyc = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    @(negedge clk);
    do_reset();

    // single frame
    clear_stats();
    send_frame(0, 100, 1'b0);
    idle(35);
    check("t1_latency", 64'(first_cyc), 64'(last_edge + 1));
    check("t1_run", 64'(max_run), 64'd25);
    check("t1_drained", 64'(q.size()), 64'd0);

    // four continuous frames
    clear_stats();
    for (int f = 0; f < 4; f++) send_frame(25 * f, 1000 + 25 * f, 1'b0);
    idle(35);
    check("t2_run", 64'(max_run), 64'd100);
    check("t2_count", 64'(seen), 64'd100);
    check("t2_drained", 64'(q.size()), 64'd0);

    // gapped input
    clear_stats();
    send_frame(0, 100, 1'b1);
    idle(35);
    check("t3_latency", 64'(first_cyc), 64'(last_edge + 1));
    check("t3_run", 64'(max_run), 64'd25);
    check("t3_drained", 64'(q.size()), 64'd0);

    // reset mid-write
    for (int n = 0; n < 12; n++) send(900 + n, 950 + n);
    @(negedge clk);
    do_reset();
    clear_stats();
    send_frame(0, 100, 1'b0);
    idle(35);
    check("t4_count", 64'(seen), 64'd25);
    check("t4_drained", 64'(q.size()), 64'd0);

    // reset mid-read
    send_frame(0, 100, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid && out_index == 5'd10) hit = 1'b1;
    end
    check("t5_reached_idx10", 64'(hit), 64'd1);
    #1;
    do_reset();
    clear_stats();
    idle(35);
    check("t5_no_leftover", 64'(seen), 64'd0);
    send_frame(0, 100, 1'b0);
    idle(35);
    check("t5_count", 64'(seen), 64'd25);
    check("t5_drained", 64'(q.size()), 64'd0);

    // ping-pong boundary, frame 2 completes at frame 1 index 24
    clear_stats();
    send_frame(500, 600, 1'b0);
    send_frame(700, 800, 1'b0);
    idle(40);
    check("t6_run", 64'(max_run), 64'd50);
    check("t6_count", 64'(seen), 64'd50);
    check("t6_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
